window_scheduler: RTL and testbench

WINDOW_SCHEDULER -- requirements
Module: window_scheduler

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/window_scheduler_beat_counter.sv | 63 ++++++
 rtl/window_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_window_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnn_pkg : scheduler state encoding and beat-position width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ROW  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  // Width holding 0..n-1; a single-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(input int size);
    return cnt_w(size + 2);
  endfunction

  function automatic int ch_w(input int channel);
    return cnt_w(channel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_scheduler_beat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// beat_counter : nested channel (inner) / column (outer) counter, saturating
// Rev 1.0
// ----------------------------------------------------------------------------
module beat_counter
  import cnn_pkg::*;
#(
  parameter int SIZE    = 28,
  parameter int CHANNEL = 128
) (
  input  logic                     i_sclk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [ch_w(CHANNEL)-1:0] o_ch_nxt,
  output logic [col_w(SIZE)-1:0]   o_col_nxt,
  output logic                     o_last
);

  localparam int COL_W = col_w(SIZE);
  localparam int CH_W  = ch_w(CHANNEL);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE + 1);

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [COL_W-1:0] col_q, col_d;

  assign o_last = (ch_q == CH_LAST) && (col_q == COL_LAST);

  // Holds at the terminal beat until cleared, so it never wraps.
  always_comb begin
    ch_d  = ch_q;
    col_d = col_q;
    if (i_clr) begin
      ch_d  = '0;
      col_d = '0;
    end else if (i_en && !o_last) begin
      if (ch_q == CH_LAST) begin
        ch_d  = '0;
        col_d = col_q + COL_W'(1);
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      ch_q  <= '0;
      col_q <= '0;
    end else begin
      ch_q  <= ch_d;
      col_q <= col_d;
    end
  end

  assign o_ch_nxt  = ch_d;
  assign o_col_nxt = col_d;

endmodule
`default_nettype wire

// File: rtl/window_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// window_scheduler : paces padded output rows from line-FIFO row arrivals
// Rev 1.0
// ----------------------------------------------------------------------------
module window_scheduler
  import cnn_pkg::*;
#(
  parameter int         SIZE    = 28,
  parameter int         CHANNEL = 128,
  parameter logic [3:0] GAP     = 4'd0,
  parameter int         PADWAIT = 21
) (
  input  logic                    i_sclk,
  input  logic                    i_rst_n,
  input  logic                    i_vsync,
  input  logic                    i_hsync,
  output logic                    o_rdreq,
  output logic                    o_vsync,
  output logic                    o_hsync,
  output logic                    o_valid,
  output logic                    o_reuse,
  output logic                    o_pad,
  output logic [$clog2(SIZE)-1:0] o_row,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int ROW_W = $clog2(SIZE);
  localparam int COL_W = col_w(SIZE);
  localparam int CH_W  = ch_w(CHANNEL);
  localparam int GAP_N = int'(GAP);
  localparam int DLY_W = cnt_w((PADWAIT > GAP_N) ? PADWAIT : GAP_N);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SIZE - 1);
  localparam logic [COL_W-1:0] COL_SIZE  = COL_W'(SIZE);
  localparam logic [COL_W-1:0] COL_RPAD  = COL_W'(SIZE + 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNEL - 1);
  localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'(PADWAIT - 1);
  localparam logic [DLY_W-1:0] GAP_LAST  = DLY_W'(GAP_N - 1);

  sched_state_e     state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       pend_q, pend_d;
  logic             err_q, err_d;

  logic rdreq_q, rdreq_d;
  logic vsync_q, vsync_d;
  logic hsync_q, hsync_d;
  logic valid_q, valid_d;
  logic reuse_q, reuse_d;
  logic pad_q, pad_d;
  logic done_q, done_d;
  logic err_out_q, err_out_d;

  logic             beat_last;
  logic             beat_clr;
  logic             beat_en;
  logic [CH_W-1:0]  ch_nxt;
  logic [COL_W-1:0] col_nxt;

  assign beat_en  = (state_q == ST_ROW);
  assign beat_clr = i_vsync || (state_q != ST_ROW);

  beat_counter #(
    .SIZE    (SIZE),
    .CHANNEL (CHANNEL)
  ) u_beat_counter (
    .i_sclk    (i_sclk),
    .i_rst_n   (i_rst_n),
    .i_clr     (beat_clr),
    .i_en      (beat_en),
    .o_ch_nxt  (ch_nxt),
    .o_col_nxt (col_nxt),
    .o_last    (beat_last)
  );

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    row_d   = row_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (i_vsync) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      row_d   = '0;
      pend_d  = '0;
    end else begin
      // Rows announced while busy are banked; an IDLE start spends one.
      if (state_q == ST_IDLE) begin
        if ((pend_q != 2'd0) && !i_hsync) begin
          pend_d = pend_q - 2'd1;
        end
      end else if (i_hsync) begin
        if (pend_q == 2'd3) begin
          err_d = 1'b1;
        end else begin
          pend_d = pend_q + 2'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (i_hsync || (pend_q != 2'd0)) begin
            dly_d   = '0;
            state_d = (PADWAIT == 0) ? ST_ROW : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dly_q == WAIT_LAST) begin
            dly_d   = '0;
            state_d = ST_ROW;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        ST_ROW: begin
          if (beat_last) begin
            dly_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = (GAP == 4'd0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (dly_q == GAP_LAST) begin
            dly_d   = '0;
            state_d = ST_IDLE;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        ST_DONE: begin
          row_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-cycle position so the registers line up
  // with the beat they describe; rdreq looks one beat ahead for FIFO latency.
  always_comb begin
    rdreq_d   = 1'b0;
    hsync_d   = 1'b0;
    valid_d   = 1'b0;
    reuse_d   = 1'b0;
    pad_d     = 1'b0;
    done_d    = 1'b0;
    vsync_d   = i_vsync;
    err_out_d = err_d && !i_vsync;
    if (!i_vsync) begin
      if (state_d == ST_ROW) begin
        hsync_d = (state_q != ST_ROW);
        pad_d   = (col_nxt == '0) || (col_nxt == COL_RPAD);
        valid_d = !pad_d;
        reuse_d = (ch_nxt != '0);
        rdreq_d = ((col_nxt < COL_SIZE) && (ch_nxt == CH_LAST)) ||
                  (!pad_d && (ch_nxt != CH_LAST));
      end
      done_d = (state_d == ST_DONE);
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      dly_q     <= '0;
      row_q     <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
      rdreq_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      valid_q   <= 1'b0;
      reuse_q   <= 1'b0;
      pad_q     <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      rdreq_q   <= rdreq_d;
      vsync_q   <= vsync_d;
      hsync_q   <= hsync_d;
      valid_q   <= valid_d;
      reuse_q   <= reuse_d;
      pad_q     <= pad_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
    end
  end

  assign o_rdreq = rdreq_q;
  assign o_vsync = vsync_q;
  assign o_hsync = hsync_q;
  assign o_valid = valid_q;
  assign o_reuse = reuse_q;
  assign o_pad   = pad_q;
  assign o_row   = row_q;
  assign o_done  = done_q;
  assign o_err   = err_out_q;

endmodule
`default_nettype wire

// File: tb/tb_window_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_window_scheduler : beat-table scoreboard bench for window_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_window_scheduler;

  localparam int         SIZE    = 4;
  localparam int         CHANNEL = 2;
  localparam logic [3:0] GAP     = 4'd1;
  localparam int         PADWAIT = 3;
  localparam int         BEATS   = (SIZE + 2) * CHANNEL;
  localparam int         ROW_W   = $clog2(SIZE);
  // Last beat -> GAP -> one IDLE cycle -> PADWAIT -> first beat of next row.
  localparam int         BURST_SPACING = int'(GAP) + PADWAIT + 2;
  localparam logic [31:0] VSYNC_ONLY = 32'h200;

  typedef struct packed {
    logic pad;
    logic valid;
    logic reuse;
    logic rdreq;
  } beat_vec_t;

  typedef struct packed {
    logic             hsync;
    logic             pad;
    logic             valid;
    logic             reuse;
    logic             rdreq;
    logic [ROW_W-1:0] row;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync_i;
  logic             hsync_i;
  logic             o_rdreq, o_vsync, o_hsync, o_valid, o_reuse, o_pad;
  logic [ROW_W-1:0] o_row;
  logic             o_done, o_err;

  beat_vec_t        beat_tab [BEATS];
  exp_t             exp_q [$];
  exp_t             mon_e;
  logic [ROW_W-1:0] exp_row;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int last_beat_cyc = -1;
  bit chk_spacing = 1'b0;
  bit done_due = 1'b0;
  bit row0_due = 1'b0;

  window_scheduler #(
    .SIZE    (SIZE),
    .CHANNEL (CHANNEL),
    .GAP     (GAP),
    .PADWAIT (PADWAIT)
  ) dut (
    .i_sclk  (clk),
    .i_rst_n (rst_n),
    .i_vsync (vsync_i),
    .i_hsync (hsync_i),
    .o_rdreq (o_rdreq),
    .o_vsync (o_vsync),
    .o_hsync (o_hsync),
    .o_valid (o_valid),
    .o_reuse (o_reuse),
    .o_pad   (o_pad),
    .o_row   (o_row),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, o_vsync, o_err, o_done, o_row, o_pad, o_reuse, o_valid, o_hsync, o_rdreq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row();
    exp_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.hsync = (b == 0);
      e.pad   = beat_tab[b].pad;
      e.valid = beat_tab[b].valid;
      e.reuse = beat_tab[b].reuse;
      e.rdreq = beat_tab[b].rdreq;
      e.row   = exp_row;
      e.last  = (b == BEATS - 1);
      exp_q.push_back(e);
    end
    exp_row = (exp_row == ROW_W'(SIZE - 1)) ? '0 : exp_row + 1'b1;
  endtask

  task automatic pulse_hsync(input bit expect_row);
    if (expect_row) push_row();
    hsync_i = 1'b1;
    tick();
    hsync_i = 1'b0;
  endtask

  task automatic wait_hsync(input int row, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_hsync && (o_row == ROW_W'(row))) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("hsync_seen", ok, 1);
  endtask

  task automatic flush_frame();
    exp_q.delete();
    exp_row = '0;
  endtask

  // Scoreboard monitor: every padded/valid beat pops one expected record.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rdreq) rd_cnt++;
      if (o_done) done_cnt++;
      if (done_due) begin
        check("done_pulse", o_done, 1);
        done_due = 1'b0;
        row0_due = 1'b1;
      end else begin
        if (row0_due) begin
          check("row_after_done", o_row, 0);
          row0_due = 1'b0;
        end
        if (o_done) check("spurious_done", o_done, 0);
      end
      if (o_pad || o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {o_pad, o_valid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", {o_hsync, o_pad, o_valid, o_reuse, o_rdreq, o_row},
                {mon_e.hsync, mon_e.pad, mon_e.valid, mon_e.reuse, mon_e.rdreq, mon_e.row});
          if (o_hsync && chk_spacing && (last_beat_cyc >= 0))
            check("burst_spacing", cyc - last_beat_cyc, BURST_SPACING);
          if (mon_e.last) begin
            last_beat_cyc = cyc;
            if (mon_e.row == ROW_W'(SIZE - 1)) done_due = 1'b1;
          end
        end
      end else if (o_rdreq || o_hsync || o_reuse) begin
        check("idle_outputs", {o_rdreq, o_hsync, o_reuse}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, r0, d0;
    // pad, valid, reuse, rdreq for each beat of a SIZE=4, CHANNEL=2 row
    beat_tab = '{4'b1000, 4'b1011, 4'b0101, 4'b0111, 4'b0101, 4'b0111,
                 4'b0101, 4'b0111, 4'b0101, 4'b0110, 4'b1000, 4'b1010};
    exp_row = '0;
    rst_n   = 1'b0;
    vsync_i = 1'b0;
    hsync_i = 1'b0;
    tick();
    tick();
    vsync_i = 1'b1;
    tick();
    check("reset_outputs", outs(), 0);
    vsync_i = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("idle_after_reset", outs(), 0);

    // Single row: latency, beat pattern and read count
    r0 = rd_cnt;
    c0 = cyc;
    pulse_hsync(1'b1);
    wait_hsync(0, 20);
    check("first_hsync_latency", cyc - c0, PADWAIT + 1);
    repeat (16) tick();
    check("row_reads", rd_cnt - r0, SIZE * CHANNEL);
    check("row_drained", exp_q.size(), 0);

    vsync_i = 1'b1;
    tick();
    check("vsync_outputs", outs(), VSYNC_ONLY);
    flush_frame();
    vsync_i = 1'b0;
    tick();

    // Full frame with widely spaced rows
    r0 = rd_cnt;
    d0 = done_cnt;
    for (int i = 0; i < SIZE; i++) begin
      pulse_hsync(1'b1);
      repeat (19) tick();
    end
    repeat (5) tick();
    check("frame_reads", rd_cnt - r0, SIZE * SIZE * CHANNEL);
    check("frame_done_count", done_cnt - d0, 1);
    check("frame_drained", exp_q.size(), 0);
    check("frame_row_zero", o_row, 0);

    // Burst: three more rows announced during row 0
    d0 = done_cnt;
    last_beat_cyc = -1;
    chk_spacing = 1'b1;
    pulse_hsync(1'b1);
    wait_hsync(0, 20);
    for (int i = 0; i < 3; i++) begin
      pulse_hsync(1'b1);
      tick();
    end
    repeat (80) tick();
    chk_spacing = 1'b0;
    check("burst_no_err", o_err, 0);
    check("burst_done_count", done_cnt - d0, 1);
    check("burst_drained", exp_q.size(), 0);

    // Abort at the sixth beat of row 2, then restart at row 0
    for (int i = 0; i < 2; i++) begin
      pulse_hsync(1'b1);
      repeat (19) tick();
    end
    pulse_hsync(1'b1);
    wait_hsync(2, 20);
    repeat (5) tick();
    vsync_i = 1'b1;
    tick();
    check("abort_outputs", outs(), VSYNC_ONLY);
    flush_frame();
    vsync_i = 1'b0;
    tick();
    check("abort_released", outs(), 0);
    pulse_hsync(1'b1);
    wait_hsync(0, 20);
    check("restart_row", o_row, 0);

    // Overflow: four extra announcements during the same row
    for (int i = 0; i < 4; i++) begin
      pulse_hsync(1'b0);
      tick();
    end
    check("err_set", o_err, 1);
    vsync_i = 1'b1;
    tick();
    check("err_masked_in_vsync", outs(), VSYNC_ONLY);
    flush_frame();
    tick();
    vsync_i = 1'b0;
    tick();
    check("err_sticky", o_err, 1);
    r0 = rd_cnt;
    repeat (20) tick();
    check("no_read_after_abort", rd_cnt - r0, 0);
    check("err_still_set", o_err, 1);

    // Reset while waiting for the line FIFO
    pulse_hsync(1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    check("reset_mid_wait", outs(), 0);
    rst_n = 1'b1;
    flush_frame();
    r0 = rd_cnt;
    repeat (25) tick();
    check("no_read_after_reset", rd_cnt - r0, 0);
    check("idle_after_mid_reset", outs(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
